// File: rtl/interruption_logic_mc.sv
// Task-interruption controller: gates NUM_CLKS task clock domains through
// per-domain BUFGCE enables, provides a domain-0 cycle counter with
// breakpoint, masked multi-cycle stepping, and a stop/decouple/PR
// handshake towards the task-interface wrappers.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal operation, watching for break_hit rise or ti_req
// STOP     | stop_req asserted to all wrappers, waiting for all acks
// DECOUPLE | wrappers decoupled, task clocks gated, waiting for pr_done
// RESUME   | stop_req released, waiting for all acks to drop
module interruption_logic_mc #(
    parameter int NUM_TI_WRAPPERS = 1,
    parameter int NUM_CLKS        = 2,
    parameter int CNT_W           = 32,
    parameter int STEP_W          = 16
) (
    input  logic                       sys_clk,
    input  logic                       sys_reset,
    input  logic                       clk_en,
    input  logic                       bp_en,
    input  logic [CNT_W-1:0]           breakpoint,
    input  logic                       break_clr,
    input  logic                       step_req,
    input  logic [STEP_W-1:0]          step_count,
    input  logic [NUM_CLKS-1:0]        step_mask,
    input  logic                       ti_req,
    input  logic                       pr_done,
    input  logic [NUM_TI_WRAPPERS-1:0] stop_ack,
    output logic [NUM_CLKS-1:0]        clk_ce,
    output logic [NUM_TI_WRAPPERS-1:0] stop_req,
    output logic                       decouple,
    output logic [CNT_W-1:0]           cycle_count,
    output logic                       break_hit,
    output logic                       step_busy,
    output logic [1:0]                 ti_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_STOP     = 2'd1,
        ST_DECOUPLE = 2'd2,
        ST_RESUME   = 2'd3
    } ti_state_t;

    localparam logic [CNT_W-1:0]           CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [NUM_TI_WRAPPERS-1:0] ACK_ALL  = {NUM_TI_WRAPPERS{1'b1}};
    localparam logic [NUM_TI_WRAPPERS-1:0] ACK_NONE = {NUM_TI_WRAPPERS{1'b0}};
    localparam logic [STEP_W-1:0]          STEP_ONE = {{(STEP_W-1){1'b0}}, 1'b1};

    ti_state_t             state;
    logic                  clk_en_r;
    logic                  bp_en_r;
    logic [CNT_W-1:0]      breakpoint_r;
    logic                  step_req_d;
    logic                  break_hit_d;
    logic [STEP_W-1:0]     step_remaining;
    logic [NUM_CLKS-1:0]   burst_mask;
    logic                  at_bp;
    logic                  run_ce;
    logic                  step_rise;
    logic                  break_rise;
    logic [STEP_W-1:0]     step_len;

    // Enables are derived only from flops so no input port reaches a BUFGCE
    // combinationally; breakpoint controls are registered alongside clk_en.
    always_comb begin
        at_bp      = bp_en_r & (cycle_count == breakpoint_r);
        run_ce     = clk_en_r & ~break_hit & ~at_bp & ~decouple;
        clk_ce     = {NUM_CLKS{run_ce}} | (step_busy ? burst_mask : {NUM_CLKS{1'b0}});
        step_rise  = step_req & ~step_req_d;
        break_rise = break_hit & ~break_hit_d;
        step_len   = (step_count == {STEP_W{1'b0}}) ? STEP_ONE : step_count;
        ti_state   = state;
    end

    // Register the level controls and the edge-detector history.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            clk_en_r     <= 1'b0;
            bp_en_r      <= 1'b0;
            breakpoint_r <= '0;
            step_req_d   <= 1'b0;
            break_hit_d  <= 1'b0;
        end else begin
            clk_en_r     <= clk_en;
            bp_en_r      <= bp_en;
            breakpoint_r <= breakpoint;
            step_req_d   <= step_req;
            break_hit_d  <= break_hit;
        end
    end

    // Domain-0 edge counter (saturating) and sticky breakpoint flag; a set
    // in the same cycle as break_clr wins so a hit is never lost.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            cycle_count <= '0;
            break_hit   <= 1'b0;
        end else begin
            if (clk_ce[0] && (cycle_count != CNT_MAX))
                cycle_count <= cycle_count + 1'b1;
            if (at_bp && clk_en_r)
                break_hit <= 1'b1;
            else if (break_clr)
                break_hit <= 1'b0;
        end
    end

    // Step burst down-counter; the mask is captured at burst start so a
    // burst delivers a consistent set of domains until it finishes.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            step_busy      <= 1'b0;
            step_remaining <= '0;
            burst_mask     <= '0;
        end else if (step_busy) begin
            if (step_remaining == STEP_ONE)
                step_busy <= 1'b0;
            step_remaining <= step_remaining - STEP_ONE;
        end else if (step_rise && !decouple) begin
            step_busy      <= 1'b1;
            step_remaining <= step_len;
            burst_mask     <= step_mask;
        end
    end

    // Stop/decouple/PR handshake FSM with registered outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state    <= ST_RUN;
            stop_req <= '0;
            decouple <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (break_rise || ti_req) begin
                        state    <= ST_STOP;
                        stop_req <= ACK_ALL;
                    end
                end
                ST_STOP: begin
                    if (stop_ack == ACK_ALL) begin
                        state    <= ST_DECOUPLE;
                        decouple <= 1'b1;
                    end
                end
                ST_DECOUPLE: begin
                    if (pr_done) begin
                        state    <= ST_RESUME;
                        decouple <= 1'b0;
                        stop_req <= '0;
                    end
                end
                ST_RESUME: begin
                    if (stop_ack == ACK_NONE)
                        state <= ST_RUN;
                end
                default: begin
                    state    <= ST_RUN;
                    stop_req <= '0;
                    decouple <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_interruption_logic_mc.sv
// Directed bench for interruption_logic_mc: breakpoint, break clear, step
// bursts, staggered stop/decouple handshake, reset mid-handshake and
// counter saturation on a narrow-counter instance.
module tb_interruption_logic_mc;

    logic        sys_clk;
    logic        sys_reset;
    logic        clk_en;
    logic        bp_en;
    logic [31:0] breakpoint;
    logic        break_clr;
    logic        step_req;
    logic [15:0] step_count;
    logic [1:0]  step_mask;
    logic        ti_req;
    logic        pr_done;
    logic [1:0]  stop_ack;
    logic [1:0]  clk_ce;
    logic [1:0]  stop_req;
    logic        decouple;
    logic [31:0] cycle_count;
    logic        break_hit;
    logic        step_busy;
    logic [1:0]  ti_state;

    logic        zero1;
    logic        b_clk_en;
    logic        b_bp_en;
    logic [3:0]  b_breakpoint;
    logic [1:0]  b_clk_ce;
    logic        b_stop_req;
    logic        b_decouple;
    logic [3:0]  b_cycle_count;
    logic        b_break_hit;
    logic        b_step_busy;
    logic [1:0]  b_ti_state;

    int n_assert = 0;
    int n_fail   = 0;
    int ce0_cnt;
    int ce1_cnt;

    interruption_logic_mc #(
        .NUM_TI_WRAPPERS(2), .NUM_CLKS(2), .CNT_W(32), .STEP_W(16)
    ) dut (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .clk_en(clk_en),
        .bp_en(bp_en), .breakpoint(breakpoint), .break_clr(break_clr),
        .step_req(step_req), .step_count(step_count), .step_mask(step_mask),
        .ti_req(ti_req), .pr_done(pr_done), .stop_ack(stop_ack),
        .clk_ce(clk_ce), .stop_req(stop_req), .decouple(decouple),
        .cycle_count(cycle_count), .break_hit(break_hit),
        .step_busy(step_busy), .ti_state(ti_state)
    );

    interruption_logic_mc #(
        .NUM_TI_WRAPPERS(1), .NUM_CLKS(2), .CNT_W(4), .STEP_W(16)
    ) dut_b (
        .sys_clk(sys_clk), .sys_reset(sys_reset), .clk_en(b_clk_en),
        .bp_en(b_bp_en), .breakpoint(b_breakpoint), .break_clr(zero1),
        .step_req(zero1), .step_count(step_count), .step_mask(step_mask),
        .ti_req(zero1), .pr_done(zero1), .stop_ack(zero1),
        .clk_ce(b_clk_ce), .stop_req(b_stop_req), .decouple(b_decouple),
        .cycle_count(b_cycle_count), .break_hit(b_break_hit),
        .step_busy(b_step_busy), .ti_state(b_ti_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_reset = 1'b1; clk_en = 1'b0; bp_en = 1'b0; breakpoint = '0;
        break_clr = 1'b0; step_req = 1'b0; step_count = '0; step_mask = '0;
        ti_req = 1'b0; pr_done = 1'b0; stop_ack = '0;
        zero1 = 1'b0; b_clk_en = 1'b0; b_bp_en = 1'b0; b_breakpoint = '0;
        tick();
        tick();

        check("rst_clk_ce",      32'(clk_ce), 32'h0);
        check("rst_stop_req",    32'(stop_req), 32'h0);
        check("rst_decouple",    32'(decouple), 32'h0);
        check("rst_cycle_count", cycle_count, 32'h0);
        check("rst_break_hit",   32'(break_hit), 32'h0);
        check("rst_step_busy",   32'(step_busy), 32'h0);
        check("rst_ti_state",    32'(ti_state), 32'h0);

        // breakpoint at 5 with clk_en high straight out of reset
        sys_reset = 1'b0; clk_en = 1'b1; bp_en = 1'b1; breakpoint = 32'd5;
        ce0_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (clk_ce[0]) ce0_cnt++;
        end
        check("bp_ce0_edges",   32'(ce0_cnt), 32'd5);
        check("bp_cycle_count", cycle_count, 32'd5);
        check("bp_break_hit",   32'(break_hit), 32'h1);
        check("bp_ti_state",    32'(ti_state), 32'd1);
        check("bp_stop_req",    32'(stop_req), 32'h3);
        check("bp_decouple",    32'(decouple), 32'h0);

        // move breakpoint to 8, then clear: three more domain-0 edges
        breakpoint = 32'd8;
        tick();
        break_clr = 1'b1;
        tick();
        break_clr = 1'b0;
        ce0_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (clk_ce[0]) ce0_cnt++;
            tick();
        end
        check("clr_ce0_edges",   32'(ce0_cnt), 32'd3);
        check("clr_cycle_count", cycle_count, 32'd8);
        check("clr_break_hit",   32'(break_hit), 32'h1);

        // 3-cycle step burst on domain 1, second edge mid-burst dropped
        clk_en = 1'b0; step_count = 16'd3; step_mask = 2'b10;
        tick();
        tick();
        step_req = 1'b1;
        ce0_cnt = 0; ce1_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (clk_ce[0]) ce0_cnt++;
            if (clk_ce[1]) ce1_cnt++;
            if (i == 0) step_req = 1'b0;
            if (i == 1) step_req = 1'b1;
        end
        check("step3_ce1_edges",   32'(ce1_cnt), 32'd3);
        check("step3_ce0_edges",   32'(ce0_cnt), 32'd0);
        check("step3_cycle_count", cycle_count, 32'd8);
        check("step3_busy_done",   32'(step_busy), 32'h0);

        // step_count 0 behaves as a single cycle
        step_req = 1'b0;
        tick();
        step_count = 16'd0; step_req = 1'b1;
        ce1_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (clk_ce[1]) ce1_cnt++;
        end
        check("step0_ce1_edges", 32'(ce1_cnt), 32'd1);
        step_req = 1'b0;

        // finish the breakpoint-initiated handshake
        stop_ack = 2'b11;
        tick();
        check("hsA_decouple_state", 32'(ti_state), 32'd2);
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0; stop_ack = 2'b00;
        tick();
        check("hsA_run_state", 32'(ti_state), 32'd0);

        // free run, then ti_req handshake with acks 4 cycles apart
        bp_en = 1'b0; clk_en = 1'b1;
        tick();
        break_clr = 1'b1;
        tick();
        break_clr = 1'b0;
        tick();
        check("free_clk_ce", 32'(clk_ce), 32'h3);
        ti_req = 1'b1;
        tick();
        ti_req = 1'b0;
        check("hs_stop_req",  32'(stop_req), 32'h3);
        check("hs_stop_state", 32'(ti_state), 32'd1);
        check("hs_stop_clk_ce", 32'(clk_ce), 32'h3);
        stop_ack = 2'b01;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("hs_partial_ack_decouple", 32'(decouple), 32'h0);
        end
        stop_ack = 2'b11;
        tick();
        check("hs_decouple",       32'(decouple), 32'h1);
        check("hs_decouple_state", 32'(ti_state), 32'd2);
        check("hs_decouple_clk_ce", 32'(clk_ce), 32'h0);
        step_req = 1'b1; step_count = 16'd2; step_mask = 2'b11;
        tick();
        check("hs_step_dropped", 32'(step_busy), 32'h0);
        tick();
        check("hs_step_dropped_ce", 32'(clk_ce), 32'h0);
        step_req = 1'b0;
        pr_done = 1'b1;
        tick();
        pr_done = 1'b0;
        check("hs_resume_decouple", 32'(decouple), 32'h0);
        check("hs_resume_stop_req", 32'(stop_req), 32'h0);
        check("hs_resume_state",    32'(ti_state), 32'd3);
        check("hs_resume_clk_ce",   32'(clk_ce), 32'h3);
        stop_ack = 2'b00;
        tick();
        check("hs_back_to_run", 32'(ti_state), 32'd0);

        // reset while decoupled
        ti_req = 1'b1;
        tick();
        ti_req = 1'b0; stop_ack = 2'b11;
        tick();
        check("rstmid_in_decouple", 32'(ti_state), 32'd2);
        sys_reset = 1'b1;
        tick();
        check("rstmid_stop_req",    32'(stop_req), 32'h0);
        check("rstmid_decouple",    32'(decouple), 32'h0);
        check("rstmid_cycle_count", cycle_count, 32'h0);
        check("rstmid_ti_state",    32'(ti_state), 32'd0);
        check("rstmid_clk_ce",      32'(clk_ce), 32'h0);
        sys_reset = 1'b0; stop_ack = 2'b00; clk_en = 1'b0;

        // 4-bit counter saturates instead of wrapping
        b_clk_en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("sat_mid_count", 32'(b_cycle_count), 32'd9);
        for (int i = 0; i < 10; i++) tick();
        check("sat_final_count", 32'(b_cycle_count), 32'hF);
        check("sat_clk_ce",      32'(b_clk_ce), 32'h3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
